// File: rtl/llc_set_read_buf.sv
// LLC set read buffer: reads every way of one set, captures the set into per-way buffers
// and resolves hit / empty / selected way. Optional hit/miss counters: LLC_RD_HIT_CNT_EN.
module llc_set_read_buf #(
    parameter int WAYS         = 16,
    parameter int WAY_BITS     = $clog2(WAYS),
    parameter int SET_BITS     = 9,
    parameter int TAG_BITS     = 19,
    parameter int LINE_BITS    = 128,
    parameter int STATE_BITS   = 3,
    parameter int HPROT_BITS   = 1,
    parameter int SHARERS_BITS = 16,
    parameter int OWNER_BITS   = 4,
    parameter int RD_LATENCY   = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         rd_req_valid,
    output logic                         rd_req_ready,
    input  logic [SET_BITS-1:0]          rd_req_set,
    input  logic [TAG_BITS-1:0]          rd_req_tag,
    output logic                         arr_rd_en,
    output logic [SET_BITS-1:0]          arr_rd_set,
    input  logic [WAYS*TAG_BITS-1:0]     arr_rd_tags,
    input  logic [WAYS*STATE_BITS-1:0]   arr_rd_states,
    input  logic [WAYS*LINE_BITS-1:0]    arr_rd_lines,
    input  logic [WAYS*HPROT_BITS-1:0]   arr_rd_hprots,
    input  logic [WAYS*SHARERS_BITS-1:0] arr_rd_sharers,
    input  logic [WAYS*OWNER_BITS-1:0]   arr_rd_owners,
    input  logic [WAYS-1:0]              arr_rd_dirty,
    input  logic [WAY_BITS-1:0]          arr_rd_evict_way,
    output logic [WAYS*TAG_BITS-1:0]     tags_buf,
    output logic [WAYS*STATE_BITS-1:0]   states_buf,
    output logic [WAYS*LINE_BITS-1:0]    lines_buf,
    output logic [WAYS*HPROT_BITS-1:0]   hprots_buf,
    output logic [WAYS*SHARERS_BITS-1:0] sharers_buf,
    output logic [WAYS*OWNER_BITS-1:0]   owners_buf,
    output logic [WAYS-1:0]              dirty_bits_buf,
    output logic [WAY_BITS-1:0]          evict_way_buf,
    output logic                         lookup_valid,
    input  logic                         lookup_ready,
    output logic                         hit,
    output logic [WAY_BITS-1:0]          hit_way,
    output logic                         empty_way_found,
    output logic [WAY_BITS-1:0]          empty_way,
    output logic [WAY_BITS-1:0]          way,
`ifdef LLC_RD_HIT_CNT_EN
    output logic [31:0]                  hit_cnt,
    output logic [31:0]                  miss_cnt,
`endif
    output logic                         multi_hit_err
);

    localparam logic [STATE_BITS-1:0] INVALID = '0;

    typedef enum logic [1:0] {IDLE, WAIT, LOOKUP, RESP} state_t;

    state_t                       state_q, state_d;
    logic [2:0]                   cnt_q, cnt_d;
    logic [TAG_BITS-1:0]          tag_q, tag_d;
    logic [WAYS*TAG_BITS-1:0]     tags_buf_q, tags_buf_d;
    logic [WAYS*STATE_BITS-1:0]   states_buf_q, states_buf_d;
    logic [WAYS*LINE_BITS-1:0]    lines_buf_q, lines_buf_d;
    logic [WAYS*HPROT_BITS-1:0]   hprots_buf_q, hprots_buf_d;
    logic [WAYS*SHARERS_BITS-1:0] sharers_buf_q, sharers_buf_d;
    logic [WAYS*OWNER_BITS-1:0]   owners_buf_q, owners_buf_d;
    logic [WAYS-1:0]              dirty_buf_q, dirty_buf_d;
    logic [WAY_BITS-1:0]          evict_buf_q, evict_buf_d;
    logic                         valid_q, valid_d;
    logic                         hit_q, hit_d;
    logic [WAY_BITS-1:0]          hit_way_q, hit_way_d;
    logic                         empty_found_q, empty_found_d;
    logic [WAY_BITS-1:0]          empty_way_q, empty_way_d;
    logic [WAY_BITS-1:0]          way_q, way_d;
    logic                         multi_q, multi_d;
`ifdef LLC_RD_HIT_CNT_EN
    logic [31:0]                  hit_cnt_q, hit_cnt_d;
    logic [31:0]                  miss_cnt_q, miss_cnt_d;
`endif

    logic                         lk_hit, lk_multi, lk_empty_found;
    logic [WAY_BITS-1:0]          lk_hit_way, lk_empty_way, scan_idx;

    // Lowest matching way wins; the empty scan starts at the round-robin pointer and wraps.
    always_comb begin
        lk_hit         = 1'b0;
        lk_multi       = 1'b0;
        lk_hit_way     = '0;
        lk_empty_found = 1'b0;
        lk_empty_way   = '0;
        scan_idx       = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (states_buf_q[w*STATE_BITS +: STATE_BITS] != INVALID &&
                tags_buf_q[w*TAG_BITS +: TAG_BITS] == tag_q) begin
                if (lk_hit) lk_multi = 1'b1;
                lk_hit     = 1'b1;
                lk_hit_way = WAY_BITS'(w);
            end
        end
        for (int i = WAYS - 1; i >= 0; i--) begin
            scan_idx = evict_buf_q + WAY_BITS'(i);
            if (states_buf_q[int'(scan_idx)*STATE_BITS +: STATE_BITS] == INVALID) begin
                lk_empty_found = 1'b1;
                lk_empty_way   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        tag_d         = tag_q;
        tags_buf_d    = tags_buf_q;
        states_buf_d  = states_buf_q;
        lines_buf_d   = lines_buf_q;
        hprots_buf_d  = hprots_buf_q;
        sharers_buf_d = sharers_buf_q;
        owners_buf_d  = owners_buf_q;
        dirty_buf_d   = dirty_buf_q;
        evict_buf_d   = evict_buf_q;
        valid_d       = valid_q;
        hit_d         = hit_q;
        hit_way_d     = hit_way_q;
        empty_found_d = empty_found_q;
        empty_way_d   = empty_way_q;
        way_d         = way_q;
        multi_d       = multi_q;
`ifdef LLC_RD_HIT_CNT_EN
        hit_cnt_d     = hit_cnt_q;
        miss_cnt_d    = miss_cnt_q;
`endif
        arr_rd_en     = 1'b0;
        arr_rd_set    = '0;
        case (state_q)
            IDLE: begin
                if (rd_req_valid) begin
                    arr_rd_en  = 1'b1;
                    arr_rd_set = rd_req_set;
                    tag_d      = rd_req_tag;
                    cnt_d      = 3'(RD_LATENCY);
                    state_d    = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd1) begin
                    tags_buf_d    = arr_rd_tags;
                    states_buf_d  = arr_rd_states;
                    lines_buf_d   = arr_rd_lines;
                    hprots_buf_d  = arr_rd_hprots;
                    sharers_buf_d = arr_rd_sharers;
                    owners_buf_d  = arr_rd_owners;
                    dirty_buf_d   = arr_rd_dirty;
                    evict_buf_d   = arr_rd_evict_way;
                    cnt_d         = '0;
                    state_d       = LOOKUP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            LOOKUP: begin
                hit_d         = lk_hit;
                hit_way_d     = lk_hit_way;
                empty_found_d = lk_empty_found;
                empty_way_d   = lk_empty_way;
                way_d         = lk_hit ? lk_hit_way : (lk_empty_found ? lk_empty_way : evict_buf_q);
                multi_d       = multi_q | lk_multi;
                valid_d       = 1'b1;
                state_d       = RESP;
            end
            default: begin
                if (lookup_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
`ifdef LLC_RD_HIT_CNT_EN
                    if (hit_q) begin
                        if (hit_cnt_q != 32'hFFFF_FFFF) hit_cnt_d = hit_cnt_q + 32'd1;
                    end else begin
                        if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
                    end
`endif
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            tag_q         <= '0;
            tags_buf_q    <= '0;
            states_buf_q  <= '0;
            lines_buf_q   <= '0;
            hprots_buf_q  <= '0;
            sharers_buf_q <= '0;
            owners_buf_q  <= '0;
            dirty_buf_q   <= '0;
            evict_buf_q   <= '0;
            valid_q       <= 1'b0;
            hit_q         <= 1'b0;
            hit_way_q     <= '0;
            empty_found_q <= 1'b0;
            empty_way_q   <= '0;
            way_q         <= '0;
            multi_q       <= 1'b0;
`ifdef LLC_RD_HIT_CNT_EN
            hit_cnt_q     <= '0;
            miss_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            tag_q         <= tag_d;
            tags_buf_q    <= tags_buf_d;
            states_buf_q  <= states_buf_d;
            lines_buf_q   <= lines_buf_d;
            hprots_buf_q  <= hprots_buf_d;
            sharers_buf_q <= sharers_buf_d;
            owners_buf_q  <= owners_buf_d;
            dirty_buf_q   <= dirty_buf_d;
            evict_buf_q   <= evict_buf_d;
            valid_q       <= valid_d;
            hit_q         <= hit_d;
            hit_way_q     <= hit_way_d;
            empty_found_q <= empty_found_d;
            empty_way_q   <= empty_way_d;
            way_q         <= way_d;
            multi_q       <= multi_d;
`ifdef LLC_RD_HIT_CNT_EN
            hit_cnt_q     <= hit_cnt_d;
            miss_cnt_q    <= miss_cnt_d;
`endif
        end
    end

    assign rd_req_ready    = (state_q == IDLE);
    assign tags_buf        = tags_buf_q;
    assign states_buf      = states_buf_q;
    assign lines_buf       = lines_buf_q;
    assign hprots_buf      = hprots_buf_q;
    assign sharers_buf     = sharers_buf_q;
    assign owners_buf      = owners_buf_q;
    assign dirty_bits_buf  = dirty_buf_q;
    assign evict_way_buf   = evict_buf_q;
    assign lookup_valid    = valid_q;
    assign hit             = hit_q;
    assign hit_way         = hit_way_q;
    assign empty_way_found = empty_found_q;
    assign empty_way       = empty_way_q;
    assign way             = way_q;
    assign multi_hit_err   = multi_q;
`ifdef LLC_RD_HIT_CNT_EN
    assign hit_cnt         = hit_cnt_q;
    assign miss_cnt        = miss_cnt_q;
`endif

endmodule

// File: tb/tb_llc_set_read_buf.sv
// Directed bench for llc_set_read_buf: instance a (4 ways, latency 1), instance b (4 ways, latency 3).
module tb_llc_set_read_buf;

    localparam int W = 4, WB = 2, SB = 9, TB = 19, LB = 128, STB = 3, HB = 1, SHB = 16, OB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst;
    logic [SB-1:0]     rd_req_set;
    logic [TB-1:0]     rd_req_tag;
    logic [W*TB-1:0]   arr_tags;
    logic [W*STB-1:0]  arr_states;
    logic [W*LB-1:0]   arr_lines;
    logic [W*HB-1:0]   arr_hprots;
    logic [W*SHB-1:0]  arr_sharers;
    logic [W*OB-1:0]   arr_owners;
    logic [W-1:0]      arr_dirty;
    logic [WB-1:0]     arr_evict;

    logic req_valid_a, lookup_ready_a, req_valid_b, lookup_ready_b;

    logic              ready_a, en_a, valid_a, hit_a, efound_a, multi_a;
    logic [SB-1:0]     aset_a;
    logic [W*TB-1:0]   tags_buf_a;
    logic [W*STB-1:0]  states_buf_a;
    logic [W*LB-1:0]   lines_buf_a;
    logic [W*HB-1:0]   hprots_buf_a;
    logic [W*SHB-1:0]  sharers_buf_a;
    logic [W*OB-1:0]   owners_buf_a;
    logic [W-1:0]      dirty_buf_a;
    logic [WB-1:0]     evict_buf_a, hit_way_a, empty_way_a, way_a;

    logic              ready_b, en_b, valid_b, hit_b, efound_b, multi_b;
    logic [SB-1:0]     aset_b;
    logic [W*TB-1:0]   tags_buf_b;
    logic [W*STB-1:0]  states_buf_b;
    logic [W*LB-1:0]   lines_buf_b;
    logic [W*HB-1:0]   hprots_buf_b;
    logic [W*SHB-1:0]  sharers_buf_b;
    logic [W*OB-1:0]   owners_buf_b;
    logic [W-1:0]      dirty_buf_b;
    logic [WB-1:0]     evict_buf_b, hit_way_b, empty_way_b, way_b;
`ifdef LLC_RD_HIT_CNT_EN
    logic [31:0]       hit_cnt_a, miss_cnt_a, hit_cnt_b, miss_cnt_b;
`endif

    llc_set_read_buf #(.WAYS(W), .RD_LATENCY(1)) dut_a (
        .clk(clk), .rst(rst), .rd_req_valid(req_valid_a), .rd_req_ready(ready_a),
        .rd_req_set(rd_req_set), .rd_req_tag(rd_req_tag), .arr_rd_en(en_a), .arr_rd_set(aset_a),
        .arr_rd_tags(arr_tags), .arr_rd_states(arr_states), .arr_rd_lines(arr_lines),
        .arr_rd_hprots(arr_hprots), .arr_rd_sharers(arr_sharers), .arr_rd_owners(arr_owners),
        .arr_rd_dirty(arr_dirty), .arr_rd_evict_way(arr_evict),
        .tags_buf(tags_buf_a), .states_buf(states_buf_a), .lines_buf(lines_buf_a),
        .hprots_buf(hprots_buf_a), .sharers_buf(sharers_buf_a), .owners_buf(owners_buf_a),
        .dirty_bits_buf(dirty_buf_a), .evict_way_buf(evict_buf_a),
        .lookup_valid(valid_a), .lookup_ready(lookup_ready_a), .hit(hit_a), .hit_way(hit_way_a),
        .empty_way_found(efound_a), .empty_way(empty_way_a), .way(way_a),
`ifdef LLC_RD_HIT_CNT_EN
        .hit_cnt(hit_cnt_a), .miss_cnt(miss_cnt_a),
`endif
        .multi_hit_err(multi_a));

    llc_set_read_buf #(.WAYS(W), .RD_LATENCY(3)) dut_b (
        .clk(clk), .rst(rst), .rd_req_valid(req_valid_b), .rd_req_ready(ready_b),
        .rd_req_set(rd_req_set), .rd_req_tag(rd_req_tag), .arr_rd_en(en_b), .arr_rd_set(aset_b),
        .arr_rd_tags(arr_tags), .arr_rd_states(arr_states), .arr_rd_lines(arr_lines),
        .arr_rd_hprots(arr_hprots), .arr_rd_sharers(arr_sharers), .arr_rd_owners(arr_owners),
        .arr_rd_dirty(arr_dirty), .arr_rd_evict_way(arr_evict),
        .tags_buf(tags_buf_b), .states_buf(states_buf_b), .lines_buf(lines_buf_b),
        .hprots_buf(hprots_buf_b), .sharers_buf(sharers_buf_b), .owners_buf(owners_buf_b),
        .dirty_bits_buf(dirty_buf_b), .evict_way_buf(evict_buf_b),
        .lookup_valid(valid_b), .lookup_ready(lookup_ready_b), .hit(hit_b), .hit_way(hit_way_b),
        .empty_way_found(efound_b), .empty_way(empty_way_b), .way(way_b),
`ifdef LLC_RD_HIT_CNT_EN
        .hit_cnt(hit_cnt_b), .miss_cnt(miss_cnt_b),
`endif
        .multi_hit_err(multi_b));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Data that must never reach the buffers: all ways valid, unmatched tags, pointer 3.
    task automatic drive_garbage();
        arr_tags    = {W{19'h7FFFF}};
        arr_states  = {W{3'd1}};
        arr_lines   = '0;
        arr_hprots  = '0;
        arr_sharers = '0;
        arr_owners  = '0;
        arr_dirty   = '0;
        arr_evict   = 2'd3;
    endtask

    task automatic drive_good(input logic [W*TB-1:0] t, input logic [W*STB-1:0] s, input logic [WB-1:0] ev);
        arr_tags    = t;
        arr_states  = s;
        arr_lines   = {16{t[31:0]}};
        arr_hprots  = 4'b0110;
        arr_sharers = {4{16'hBEEF}};
        arr_owners  = 16'h4321;
        arr_dirty   = 4'b1010;
        arr_evict   = ev;
    endtask

    // Issue one request on instance sel; good array data is present only in the capture cycle.
    task automatic run_lookup(input bit sel, input int lat, input logic [SB-1:0] set, input logic [TB-1:0] tag,
                              input logic [W*TB-1:0] t, input logic [W*STB-1:0] s, input logic [WB-1:0] ev);
        int n;
        drive_garbage();
        rd_req_set = set;
        rd_req_tag = tag;
        if (sel) req_valid_b = 1'b1; else req_valid_a = 1'b1;
        #1;
        chk("arr_rd_en_hs", sel ? en_b : en_a, 1'b1);
        chk("arr_rd_set_hs", sel ? aset_b : aset_a, set);
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        req_valid_b = 1'b0;
        chk("rd_req_ready_busy", sel ? ready_b : ready_a, 1'b0);
        n = 1;
        while (n < 20) begin
            if (n == lat) drive_good(t, s, ev);
            if (n == lat + 1) drive_garbage();
            if (sel ? valid_b : valid_a) break;
            @(posedge clk); #1;
            n++;
        end
        chk("latency", n, lat + 2);
    endtask

    initial begin
        rst = 1'b1;
        req_valid_a = 1'b0; req_valid_b = 1'b0;
        lookup_ready_a = 1'b0; lookup_ready_b = 1'b0;
        rd_req_set = '0; rd_req_tag = '0;
        drive_garbage();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_ready", ready_a, 1'b1);
        chk("rst_valid", valid_a, 1'b0);
        chk("rst_hit", hit_a, 1'b0);
        chk("rst_way", way_a, 2'd0);
        chk("rst_efound", efound_a, 1'b0);
        chk("rst_tags_buf", tags_buf_a, '0);
        chk("rst_multi", multi_a, 1'b0);
        chk("rst_arr_rd_en", en_a, 1'b0);

        // Hit in way 2
        run_lookup(0, 1, 9'd5, 19'h123, {19'h0, 19'h123, 19'h0, 19'h0}, {3'd0, 3'd1, 3'd0, 3'd0}, 2'd0);
        chk("t1_hit", hit_a, 1'b1);
        chk("t1_hit_way", hit_way_a, 2'd2);
        chk("t1_way", way_a, 2'd2);
        chk("t1_efound", efound_a, 1'b1);
        chk("t1_empty_way", empty_way_a, 2'd0);
        chk("t1_multi", multi_a, 1'b0);
        chk("t1_tags_buf", tags_buf_a, {19'h0, 19'h123, 19'h0, 19'h0});
        chk("t1_dirty_buf", dirty_buf_a, 4'b1010);
        chk("t1_owners_buf", owners_buf_a, 16'h4321);
        lookup_ready_a = 1'b1;
        @(posedge clk); #1;
        lookup_ready_a = 1'b0;
        chk("t1_valid_drop", valid_a, 1'b0);
        chk("t1_ready_back", ready_a, 1'b1);
        chk("t1_tags_hold", tags_buf_a, {19'h0, 19'h123, 19'h0, 19'h0});

        // Miss, wrap scan from way 2 finds way 3
        run_lookup(0, 1, 9'd6, 19'h123, {W{19'h0AA}}, {3'd0, 3'd1, 3'd1, 3'd0}, 2'd2);
        chk("t2_hit", hit_a, 1'b0);
        chk("t2_efound", efound_a, 1'b1);
        chk("t2_empty_way", empty_way_a, 2'd3);
        chk("t2_way", way_a, 2'd3);
        lookup_ready_a = 1'b1;
        @(posedge clk); #1;
        lookup_ready_a = 1'b0;

        // All valid, no match: evict pointer selected; consumer stalls 5 cycles
        run_lookup(0, 1, 9'd7, 19'h123, {19'h4, 19'h3, 19'h2, 19'h1}, {W{3'd2}}, 2'd1);
        chk("t3_hit", hit_a, 1'b0);
        chk("t3_efound", efound_a, 1'b0);
        chk("t3_way", way_a, 2'd1);
        chk("t3_evict_buf", evict_buf_a, 2'd1);
        rd_req_set = 9'd8;
        req_valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("stall_valid", valid_a, 1'b1);
            chk("stall_way", way_a, 2'd1);
            chk("stall_ready", ready_a, 1'b0);
            chk("stall_arr_rd_en", en_a, 1'b0);
        end
        lookup_ready_a = 1'b1;
        @(posedge clk); #1;
        lookup_ready_a = 1'b0;
        chk("t4_valid_drop", valid_a, 1'b0);
        chk("t4_ready_next", ready_a, 1'b1);
        chk("t4_accept_next", en_a, 1'b1);
        req_valid_a = 1'b0;
        #1;

        // Latency 3 instance: ways 0 and 1 both match
        run_lookup(1, 3, 9'h1A, 19'h055, {19'h0, 19'h0, 19'h055, 19'h055}, {3'd0, 3'd0, 3'd1, 3'd1}, 2'd0);
        chk("t5_hit", hit_b, 1'b1);
        chk("t5_multi", multi_b, 1'b1);
        chk("t5_hit_way", hit_way_b, 2'd0);
        chk("t5_way", way_b, 2'd0);
        chk("t5_empty_way", empty_way_b, 2'd2);
        lookup_ready_b = 1'b1;
        @(posedge clk); #1;
        lookup_ready_b = 1'b0;
        chk("t5_multi_sticky", multi_b, 1'b1);

        // Reset during WAIT aborts the request
        drive_garbage();
        rd_req_set = 9'd3;
        req_valid_a = 1'b1;
        @(posedge clk); #1;
        req_valid_a = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t6_ready", ready_a, 1'b1);
        chk("t6_valid", valid_a, 1'b0);
        chk("t6_tags_buf", tags_buf_a, '0);
        chk("t6_states_buf", states_buf_a, '0);
        chk("t6_evict_buf", evict_buf_a, 2'd0);
        chk("t6_way", way_a, 2'd0);
        chk("t6_multi_b_clear", multi_b, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("t6_no_valid", valid_a, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
